// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with single-cycle base ops and an optional iterative multiply/divide unit.
// Define ALU_SEQ_MULDIV_EN to build ops 10-17 (MUL/DIV states); when undefined they return 0 in one cycle.
module alu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  // valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
  // the producer holds its payload stable until then, and valid never depends on ready.
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] fast_d;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign dbg_state = state_q;

  always_comb begin
    fast_d = '0;
    case (op)
      5'd0:    fast_d = a + b;
      5'd1:    fast_d = a - b;
      5'd2:    fast_d = a << b[SHW-1:0];
      5'd3:    fast_d = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      5'd4:    fast_d = {{(XLEN-1){1'b0}}, (a < b)};
      5'd5:    fast_d = a ^ b;
      5'd6:    fast_d = a >> b[SHW-1:0];
      5'd7:    fast_d = $unsigned($signed(a) >>> b[SHW-1:0]);
      5'd8:    fast_d = a | b;
      5'd9:    fast_d = a & b;
      default: fast_d = '0;
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [CW-1:0]     cnt_q;
  logic [4:0]        op_q;
  logic              sign_a_q, sign_b_q;
  logic [XLEN-1:0]   opb_q;
  logic [2*XLEN-1:0] acc_q;

  logic              is_mul, is_div, div_signed, div_zero, div_ovf, div_short;
  logic              sign_a_d, sign_b_d;
  logic [XLEN-1:0]   mag_a_d, mag_b_d, short_res_d;
  logic [XLEN:0]     mul_sum, div_part, div_diff;
  logic [2*XLEN-1:0] mul_acc_d, div_acc_d, prod_fin;
  logic [XLEN-1:0]   mul_res_d, div_res_d, quo_fin, rem_fin;

  // Operand conditioning at accept: signed ops work on magnitudes, signs are fixed up at the end.
  always_comb begin
    is_mul      = (op >= 5'd10) && (op <= 5'd13);
    is_div      = (op >= 5'd14) && (op <= 5'd17);
    div_signed  = (op == 5'd14) || (op == 5'd16);
    div_zero    = (b == '0);
    div_ovf     = div_signed && (a == MOST_NEG) && (b == {XLEN{1'b1}});
    div_short   = is_div && (div_zero || div_ovf);
    sign_a_d    = ((op == 5'd11) || (op == 5'd12) || div_signed) && a[XLEN-1];
    sign_b_d    = ((op == 5'd11) || div_signed) && b[XLEN-1];
    mag_a_d     = sign_a_d ? -a : a;
    mag_b_d     = sign_b_d ? -b : b;
    short_res_d = '0;
    if (div_zero) begin
      short_res_d = ((op == 5'd14) || (op == 5'd15)) ? {XLEN{1'b1}} : a;
    end else if (div_ovf) begin
      short_res_d = (op == 5'd14) ? a : '0;
    end
  end

  // acc_q holds {partial_hi, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_acc_d = {mul_sum, acc_q[XLEN-1:1]};
    prod_fin  = (sign_a_q ^ sign_b_q) ? -mul_acc_d : mul_acc_d;
    mul_res_d = (op_q == 5'd10) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];

    div_part  = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_part - {1'b0, opb_q};
    div_acc_d = div_diff[XLEN] ? {div_part[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    quo_fin   = (sign_a_q ^ sign_b_q) ? -div_acc_d[XLEN-1:0] : div_acc_d[XLEN-1:0];
    rem_fin   = sign_a_q ? -div_acc_d[2*XLEN-1:XLEN] : div_acc_d[2*XLEN-1:XLEN];
    div_res_d = ((op_q == 5'd14) || (op_q == 5'd15)) ? quo_fin : rem_fin;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
`ifdef ALU_SEQ_MULDIV_EN
      cnt_q    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
`ifdef ALU_SEQ_MULDIV_EN
            cnt_q    <= '0;
            op_q     <= op;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            opb_q    <= mag_b_d;
            acc_q    <= {{XLEN{1'b0}}, mag_a_d};
            if (is_mul) begin
              state_q <= S_MUL;
            end else if (is_div && !div_short) begin
              state_q <= S_DIV;
            end else begin
              result_q <= div_short ? short_res_d : fast_d;
              state_q  <= S_DONE;
            end
`else
            result_q <= fast_d;
            state_q  <= S_DONE;
`endif
          end
        end
`ifdef ALU_SEQ_MULDIV_EN
        // The final iteration writes the signed-corrected result directly, so MUL/DIV last XLEN cycles.
        S_MUL: begin
          acc_q <= mul_acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) begin
            result_q <= mul_res_d;
            state_q  <= S_DONE;
          end
        end
        S_DIV: begin
          acc_q <= div_acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) begin
            result_q <= div_res_d;
            state_q  <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq with a queue-based scoreboard and latency monitor.
// Expectations for ops 10-17 follow whether ALU_SEQ_MULDIV_EN is defined.
module tb_alu_seq;

  localparam int XLEN = 32;
`ifdef ALU_SEQ_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  localparam int ML = MD ? XLEN + 1 : 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;
  logic [4:0]      op = '0;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            in_ready;
  logic            out_valid;
  logic [XLEN-1:0] result;
  logic [1:0]      dbg_state;

  alu_seq #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];
  int              lat_q[$];
  int              acc_q[$];

  function automatic logic [XLEN-1:0] md(input logic [XLEN-1:0] v);
    return MD ? v : '0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  logic ov_seen = 1'b0;
  always @(negedge clk) begin
    int lat_exp;
    int t0;
    if (rst) begin
      ov_seen = 1'b0;
    end else begin
      if (out_valid && !ov_seen) begin
        ov_seen = 1'b1;
        if (lat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=0x%0h required=none", result);
        end else begin
          lat_exp = lat_q.pop_front();
          t0      = acc_q.pop_front();
          check("latency", 64'(cyc - t0 + 1), 64'(lat_exp));
        end
      end
      if (out_valid && out_ready) begin
        ov_seen = 1'b0;
        if (exp_q.size() != 0) check("result", result, exp_q.pop_front());
      end
    end
  end

  // driver tasks; each is entered and left just after a rising edge
  task automatic issue(input logic [4:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                       input logic [XLEN-1:0] exp, input int lat, input bit push);
    int n = 0;
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high op=%0d", o);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    @(posedge clk);
    #1;
    if (push) begin
      exp_q.push_back(exp);
      lat_q.push_back(lat);
      acc_q.push_back(cyc);
    end
    in_valid = 1'b0;
    op = 5'($urandom_range(0, 31));
    a = $urandom;
    b = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while ((!in_ready || exp_q.size() != 0) && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready || exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=pending_%0d required=pending_0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
      acc_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [4:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                     input logic [XLEN-1:0] exp, input int lat);
    issue(o, x, y, exp, lat, 1'b1);
    drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ADD with handshake timing
    issue(5'd0, 5, 7, 12, 1, 1'b1);
    @(negedge clk);
    check("add_out_valid", out_valid, 1);
    check("add_in_ready_busy", in_ready, 0);
    @(negedge clk);
    check("add_in_ready_back", in_ready, 1);
    check("add_out_valid_low", out_valid, 0);
    @(posedge clk);
    #1;

    run(5'd1, 3, 5, 32'hFFFF_FFFE, 1);
    run(5'd2, 1, 32'h21, 2, 1);
    run(5'd3, 32'hFFFF_FFFF, 1, 1, 1);
    run(5'd3, 1, 32'hFFFF_FFFF, 0, 1);
    run(5'd4, 1, 32'hFFFF_FFFF, 1, 1);
    run(5'd5, 32'hF0F0, 32'hFF00, 32'h0FF0, 1);
    run(5'd6, 32'h8000_0000, 4, 32'h0800_0000, 1);
    run(5'd7, 32'h8000_0000, 32'h24, 32'hF800_0000, 1);
    run(5'd8, 32'hF0, 32'h0F, 32'hFF, 1);
    run(5'd9, 32'hF0, 32'h3C, 32'h30, 1);
    run(5'd25, 1, 2, 0, 1);
    run(5'd31, 32'hFFFF, 1, 0, 1);

    run(5'd10, 32'hFFFF_FFFF, 2, md(32'hFFFF_FFFE), ML);
    run(5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, ML);
    run(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, md(32'hFFFF_FFFE), ML);
    run(5'd12, 32'hFFFF_FFFF, 2, md(32'hFFFF_FFFF), ML);
    run(5'd11, 7, 32'hFFFF_FFFD, md(32'hFFFF_FFFF), ML);
    run(5'd14, 32'hFFFF_FFF9, 2, md(32'hFFFF_FFFD), ML);
    run(5'd16, 32'hFFFF_FFF9, 2, md(32'hFFFF_FFFF), ML);
    run(5'd14, 7, 32'hFFFF_FFFE, md(32'hFFFF_FFFD), ML);
    run(5'd16, 7, 32'hFFFF_FFFE, md(1), ML);
    run(5'd15, 100, 7, md(14), ML);
    run(5'd17, 100, 7, md(2), ML);
    run(5'd15, 5, 0, md(32'hFFFF_FFFF), 1);
    run(5'd17, 9, 0, md(9), 1);
    run(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, md(32'h8000_0000), 1);
    run(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1);

    // result held under back-pressure, new requests ignored
    issue(5'd0, 20, 22, 42, 1, 1'b1);
    out_ready = 1'b0;
    in_valid = 1'b1;
    op = 5'd0;
    a = 1;
    b = 1;
    repeat (3) begin
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_result", result, 42);
      check("hold_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);
    @(posedge clk);
    #1;

    // reset in the middle of a DIVU
    issue(5'd15, 1000, 3, 0, 1, !MD);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_result", result, 0);
    check("abort_state", dbg_state, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run(5'd0, 1, 1, 2, 1);
    run(5'd10, 3, 3, md(9), ML);

    drain();
    check("queue_empty", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
